// File: rtl/picorv_freeahb_adapter.sv
// PicoRV32 native memory port to FreeAHB ahb_master user-port bridge; one core transfer becomes one single-beat AHB transfer.
// Optional build macro PICORV_FREEAHB_INSTR_PROT_EN marks opcode fetches in HPROT[0]; otherwise HPROT is privileged data.
module picorv_freeahb_adapter (
  input  logic        clk,
  input  logic        resetn,
  input  logic        mem_valid,
  input  logic        mem_instr,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_wstrb,
  output logic        mem_ready,
  output logic [31:0] mem_rdata,
  output logic        freeahb_valid,
  output logic [31:0] freeahb_addr,
  output logic [31:0] freeahb_wdata,
  output logic [2:0]  freeahb_size,
  output logic        freeahb_write,
  output logic        freeahb_read,
  output logic [31:0] freeahb_min_len,
  output logic        freeahb_cont,
  output logic [3:0]  freeahb_prot,
  output logic        freeahb_lock,
  input  logic        freeahb_next,
  input  logic [31:0] freeahb_rdata,
  input  logic [31:0] freeahb_result_addr,
  input  logic        freeahb_ready
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REQ    = 2'd1,
    RDWAIT = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic        valid_q, valid_d;
  logic        write_q, write_d;
  logic        read_q, read_d;
  logic        ready_q, ready_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [2:0]  size_q, size_d;
  logic [3:0]  prot_q, prot_d;
  logic [31:0] rdata_q, rdata_d;
  logic [4:0]  map_w;

  // Strobe pattern -> {HSIZE, byte offset}; irregular patterns fall back to a full word.
  always_comb begin
    map_w = {3'b010, 2'b00};
    case (mem_wstrb)
      4'b0001: map_w = {3'b000, 2'b00};
      4'b0010: map_w = {3'b000, 2'b01};
      4'b0100: map_w = {3'b000, 2'b10};
      4'b1000: map_w = {3'b000, 2'b11};
      4'b0011: map_w = {3'b001, 2'b00};
      4'b1100: map_w = {3'b001, 2'b10};
      default: map_w = {3'b010, 2'b00};
    endcase
  end

  always_comb begin
    state_d = state_q;
    valid_d = valid_q;
    write_d = write_q;
    read_d  = read_q;
    ready_d = ready_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    size_d  = size_q;
    rdata_d = rdata_q;
`ifdef PICORV_FREEAHB_INSTR_PROT_EN
    prot_d  = prot_q;
`else
    prot_d  = 4'b0011;
`endif
    case (state_q)
      IDLE: begin
        ready_d = 1'b0;
        if (mem_valid) begin
          state_d = REQ;
          valid_d = 1'b1;
          write_d = |mem_wstrb;
          read_d  = ~|mem_wstrb;
          addr_d  = {mem_addr[31:2], map_w[1:0]};
          size_d  = map_w[4:2];
          wdata_d = mem_wdata;
`ifdef PICORV_FREEAHB_INSTR_PROT_EN
          prot_d  = {3'b001, ~mem_instr};
`endif
        end
      end
      REQ: begin
        if (freeahb_next) begin
          valid_d = 1'b0;
          if (write_q) begin
            // Posted write: the core is released as soon as the master takes the request.
            write_d = 1'b0;
            ready_d = 1'b1;
            state_d = DONE;
          end else if (freeahb_ready) begin
            rdata_d = freeahb_rdata;
            read_d  = 1'b0;
            ready_d = 1'b1;
            state_d = DONE;
          end else begin
            state_d = RDWAIT;
          end
        end
      end
      RDWAIT: begin
        if (freeahb_ready) begin
          rdata_d = freeahb_rdata;
          read_d  = 1'b0;
          ready_d = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        ready_d = 1'b0;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        valid_d = 1'b0;
        write_d = 1'b0;
        read_d  = 1'b0;
        ready_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      valid_q <= 1'b0;
      write_q <= 1'b0;
      read_q  <= 1'b0;
      ready_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      size_q  <= '0;
      prot_q  <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      write_q <= write_d;
      read_q  <= read_d;
      ready_q <= ready_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      size_q  <= size_d;
      prot_q  <= prot_d;
      rdata_q <= rdata_d;
    end
  end

  assign mem_ready       = ready_q;
  assign mem_rdata       = rdata_q;
  assign freeahb_valid   = valid_q;
  assign freeahb_addr    = addr_q;
  assign freeahb_wdata   = wdata_q;
  assign freeahb_size    = size_q;
  assign freeahb_write   = write_q;
  assign freeahb_read    = read_q;
  assign freeahb_prot    = prot_q;
  assign freeahb_min_len = 32'd0;
  assign freeahb_cont    = 1'b0;
  assign freeahb_lock    = 1'b0;

  logic unused_sig;
  assign unused_sig = ^{freeahb_result_addr, mem_addr[1:0], mem_instr};

endmodule

// File: tb/tb_picorv_freeahb_adapter.sv
// Bench for picorv_freeahb_adapter: directed cases plus randomized transfers against a transaction-level model.
module tb_picorv_freeahb_adapter;
  logic        clk = 1'b0;
  logic        resetn;
  logic        mem_valid, mem_instr;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic        freeahb_valid;
  logic [31:0] freeahb_addr, freeahb_wdata;
  logic [2:0]  freeahb_size;
  logic        freeahb_write, freeahb_read;
  logic [31:0] freeahb_min_len;
  logic        freeahb_cont;
  logic [3:0]  freeahb_prot;
  logic        freeahb_lock;
  logic        freeahb_next;
  logic [31:0] freeahb_rdata, freeahb_result_addr;
  logic        freeahb_ready;

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] exp_rdata = 32'd0;

  always #5 clk = ~clk;

  picorv_freeahb_adapter dut (
    .clk(clk), .resetn(resetn),
    .mem_valid(mem_valid), .mem_instr(mem_instr), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_ready(mem_ready),
    .mem_rdata(mem_rdata), .freeahb_valid(freeahb_valid), .freeahb_addr(freeahb_addr),
    .freeahb_wdata(freeahb_wdata), .freeahb_size(freeahb_size), .freeahb_write(freeahb_write),
    .freeahb_read(freeahb_read), .freeahb_min_len(freeahb_min_len), .freeahb_cont(freeahb_cont),
    .freeahb_prot(freeahb_prot), .freeahb_lock(freeahb_lock), .freeahb_next(freeahb_next),
    .freeahb_rdata(freeahb_rdata), .freeahb_result_addr(freeahb_result_addr),
    .freeahb_ready(freeahb_ready)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: a lone strobe bit is a byte at that lane, an aligned half pair is a halfword, anything else a word.
  function automatic logic [2:0] ref_size(input logic [3:0] s);
    if ($countones(s) == 1) return 3'd0;
    if (s == 4'b0011 || s == 4'b1100) return 3'd1;
    return 3'd2;
  endfunction

  function automatic logic [31:0] ref_addr(input logic [31:0] a, input logic [3:0] s);
    logic [31:0] base;
    base = a & 32'hFFFF_FFFC;
    if ($countones(s) == 1) begin
      for (int i = 0; i < 4; i++) if (s[i]) return base + i;
    end
    if (s == 4'b1100) return base + 2;
    return base;
  endfunction

  function automatic logic [3:0] ref_prot(input logic instr);
`ifdef PICORV_FREEAHB_INSTR_PROT_EN
    return instr ? 4'b0010 : 4'b0011;
`else
    return (instr & 1'b0) ? 4'b0000 : 4'b0011;
`endif
  endfunction

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ready"}, {31'd0, mem_ready}, 32'd0);
    chk({tag, "_rdata"}, mem_rdata, 32'd0);
    chk({tag, "_valid"}, {31'd0, freeahb_valid}, 32'd0);
    chk({tag, "_addr"}, freeahb_addr, 32'd0);
    chk({tag, "_wdata"}, freeahb_wdata, 32'd0);
    chk({tag, "_rw"}, {29'd0, freeahb_size, freeahb_write, freeahb_read}, 32'd0);
    chk({tag, "_prot"}, {28'd0, freeahb_prot}, 32'd0);
    chk({tag, "_const"}, freeahb_min_len | {30'd0, freeahb_cont, freeahb_lock}, 32'd0);
  endtask

  // One core transfer; ndly = cycles before acceptance, rdly = cycles from acceptance to read data.
  task automatic xfer(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] st,
                      input logic ins, input int ndly, input int rdly, input logic [31:0] rd);
    logic        is_wr;
    logic [31:0] ea;
    is_wr = (st != 4'b0000);
    ea    = ref_addr(a, st);
    @(negedge clk);
    mem_valid = 1'b1; mem_addr = a; mem_wdata = wd; mem_wstrb = st; mem_instr = ins;
    @(negedge clk);
    chk("req_valid", {31'd0, freeahb_valid}, 32'd1);
    chk("req_addr", freeahb_addr, ea);
    chk("req_size", {29'd0, freeahb_size}, {29'd0, ref_size(st)});
    chk("req_wr_rd", {30'd0, freeahb_write, freeahb_read}, {30'd0, is_wr, ~is_wr});
    if (is_wr) chk("req_wdata", freeahb_wdata, wd);
    chk("req_prot", {28'd0, freeahb_prot}, {28'd0, ref_prot(ins)});
    chk("req_no_ready", {31'd0, mem_ready}, 32'd0);
    mem_addr = $urandom; mem_wdata = $urandom; mem_wstrb = 4'($urandom); mem_instr = ~ins;
    for (int i = 0; i < ndly; i++) begin
      freeahb_ready = is_wr ? 1'($urandom) : 1'b0;
      freeahb_rdata = $urandom;
      @(negedge clk);
      chk("wait_valid", {31'd0, freeahb_valid}, 32'd1);
      chk("wait_addr_frozen", freeahb_addr, ea);
      chk("wait_no_ready", {31'd0, mem_ready}, 32'd0);
    end
    freeahb_next = 1'b1;
    if (!is_wr && rdly == 0) begin
      freeahb_ready = 1'b1; freeahb_rdata = rd;
    end else begin
      freeahb_ready = is_wr ? 1'($urandom) : 1'b0;
      freeahb_rdata = $urandom;
    end
    @(negedge clk);
    freeahb_next = 1'b0; freeahb_ready = 1'b0;
    chk("acc_valid_drop", {31'd0, freeahb_valid}, 32'd0);
    if (!is_wr && rdly > 0) begin
      chk("rdwait_read", {31'd0, freeahb_read}, 32'd1);
      chk("rdwait_no_ready", {31'd0, mem_ready}, 32'd0);
      for (int i = 1; i < rdly; i++) begin
        freeahb_rdata = $urandom;
        @(negedge clk);
        chk("rdwait_hold", {31'd0, freeahb_read}, 32'd1);
        chk("rdwait_no_ready2", {31'd0, mem_ready}, 32'd0);
        chk("rdwait_rdata_held", mem_rdata, exp_rdata);
      end
      freeahb_ready = 1'b1; freeahb_rdata = rd;
      @(negedge clk);
      freeahb_ready = 1'b0; freeahb_rdata = $urandom;
    end
    if (!is_wr) exp_rdata = rd;
    chk("done_ready", {31'd0, mem_ready}, 32'd1);
    chk("done_rdata", mem_rdata, exp_rdata);
    chk("done_wr_rd", {30'd0, freeahb_write, freeahb_read}, 32'd0);
    mem_valid = 1'b0;
    @(negedge clk);
    chk("after_ready", {31'd0, mem_ready}, 32'd0);
    chk("after_valid", {31'd0, freeahb_valid}, 32'd0);
    chk("after_rdata", mem_rdata, exp_rdata);
  endtask

  initial begin
    resetn = 1'b0; mem_valid = 1'b0; mem_instr = 1'b0; mem_addr = '0; mem_wdata = '0;
    mem_wstrb = '0; freeahb_next = 1'b0; freeahb_rdata = '0; freeahb_ready = 1'b0;
    freeahb_result_addr = 32'hDEAD_BEEF;
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    resetn = 1'b1;

    xfer(32'h8000_0000, 32'hF0FF_0FAA, 4'b1111, 1'b1, 1, 0, 32'h0);
    xfer(32'h0000_1000, 32'h0, 4'b0000, 1'b0, 0, 2, 32'h1234_5678);
    xfer(32'h0000_0020, 32'h00AB_0000, 4'b0100, 1'b0, 0, 0, 32'h0);
    xfer(32'h0000_0040, 32'hBEEF_0000, 4'b1100, 1'b0, 2, 0, 32'h0);
    xfer(32'h0000_0044, 32'h0000_BEEF, 4'b0011, 1'b0, 0, 0, 32'h0);
    xfer(32'h0000_0048, 32'h1111_1111, 4'b0101, 1'b0, 0, 0, 32'h0);
    xfer(32'h0000_2000, 32'h0, 4'b0000, 1'b1, 1, 4, 32'hCAFE_F00D);
    xfer(32'h0000_3000, 32'h0, 4'b0000, 1'b0, 0, 0, 32'h5A5A_A5A5);

    // Asynchronous reset while waiting for read data.
    @(negedge clk);
    mem_valid = 1'b1; mem_addr = 32'h0000_4000; mem_wstrb = 4'b0000; mem_instr = 1'b0;
    @(negedge clk);
    freeahb_next = 1'b1;
    @(negedge clk);
    freeahb_next = 1'b0;
    chk("rst_pre_read", {31'd0, freeahb_read}, 32'd1);
    #2 resetn = 1'b0;
    #1 chk_all_zero("async_rst");
    mem_valid = 1'b0;
    @(negedge clk);
    chk_all_zero("rst_hold");
    resetn = 1'b1;
    exp_rdata = 32'd0;
    @(negedge clk);
    chk("post_rst_no_ready", {31'd0, mem_ready}, 32'd0);
    xfer(32'h0000_5000, 32'h0, 4'b0000, 1'b0, 1, 1, 32'h0BAD_CAFE);

    for (int k = 0; k < 150; k++) begin
      xfer($urandom & 32'hFFFF_FFFC, $urandom, 4'($urandom_range(0, 15)), 1'($urandom),
           int'($urandom_range(0, 3)), int'($urandom_range(0, 4)), $urandom);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
